// File: rtl/zeroriscy_d_arb.sv
// zeroriscy_d_arb: shares one single-port data SRAM between the LSU (m0) and a debug/DMA port (m1).
// Latency: zero added cycles on the request path and on the response path (both combinational).
// Backpressure: s_gnt=0 holds the selected master until it is granted; with MAX_OUT owners in flight, s_req is dropped.
// Optional: define ZERORISCY_D_ARB_RR_EN for round-robin on contention (default is fixed priority to m0).
module zeroriscy_d_arb #(
  parameter int MAX_OUT = 2,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 (core LSU)
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  // master 1 (debug / DMA)
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  // slave port towards the SRAM
  output logic          s_req,
  output logic          s_we,
  output logic [3:0]    s_be,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   s_wdata,
  input  logic          s_gnt,
  input  logic          s_rvalid,
  input  logic [31:0]   s_rdata,
  input  logic          s_err
);

  // Owner FIFO pointer and occupancy widths (pointer kept at least one bit wide).
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  // IDLE: free selection; HOLD: an ungranted request is pinned to r_held_id.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_held_id;
  logic            r_owner [MAX_OUT];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_spurious;

  logic            w_any;
  logic            w_both;
  logic            w_pop;
  logic            w_can_push;
  logic            w_issue;
  logic            w_done;
  logic            w_sel;
  logic            w_rr_pick;
  logic            w_head;

`ifdef ZERORISCY_D_ARB_RR_EN
  logic            r_last_grant;

  // Remember who completed last so the other master wins the next contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_done) begin
      r_last_grant <= w_sel;
    end
  end

  assign w_rr_pick = ~r_last_grant;
`else
  // Fixed priority: master 0 wins every contention.
  assign w_rr_pick = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_any  = m0_req | m1_req;
  assign w_both = m0_req & m1_req;

  // A response only pops when something is outstanding; a stray rvalid is swallowed.
  assign w_pop      = s_rvalid & (r_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a new issue.
  assign w_can_push = (r_count < CW'(MAX_OUT)) | w_pop;
  // Gated by rst_n so no grant or request escapes while reset is asserted.
  assign w_issue    = w_any & w_can_push & rst_n;
  assign w_done     = w_issue & s_gnt;

  // Selection and hold state: a stalled request keeps its master until granted.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = 1'b0;
    case (r_state)
      ST_HOLD: w_sel = r_held_id;
      default: begin
        if (w_both) begin
          w_sel = w_rr_pick;
        end else begin
          w_sel = m1_req;
        end
      end
    endcase
    if (w_done) begin
      w_state_nxt = ST_IDLE;
    end else if (w_issue) begin
      w_state_nxt = ST_HOLD;
    end
  end

  // Hold state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the stalled master; in HOLD w_sel already equals r_held_id so it stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_id <= 1'b0;
    end else if (w_issue && !s_gnt) begin
      r_held_id <= w_sel;
    end
  end

  // Request mux towards the SRAM.
  assign s_req   = w_issue;
  assign s_we    = w_sel ? m1_we    : m0_we;
  assign s_be    = w_sel ? m1_be    : m0_be;
  assign s_addr  = w_sel ? m1_addr  : m0_addr;
  assign s_wdata = w_sel ? m1_wdata : m0_wdata;

  assign m0_gnt  = w_done & ~w_sel;
  assign m1_gnt  = w_done &  w_sel;

  // Owner FIFO: one bit per outstanding transaction, oldest at r_rd_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_owner[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_done) begin
        r_owner[r_wr_ptr] <= w_sel;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_done, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky record of a response that arrived with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spurious <= 1'b0;
    end else if (s_rvalid && (r_count == '0)) begin
      r_spurious <= 1'b1;
    end
  end

  // Response steering: the FIFO head owns the current response.
  assign w_head    = r_owner[r_rd_ptr];
  assign m0_rvalid = w_pop & ~w_head;
  assign m1_rvalid = w_pop &  w_head;
  assign m0_err    = w_pop & ~w_head & s_err;
  assign m1_err    = w_pop &  w_head & s_err;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  // Occupancy never exceeds the FIFO depth; the spurious flag only clears on reset.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(MAX_OUT));
  a_spurious_sticky: assert property (@(posedge clk) disable iff (!rst_n) r_spurious |=> r_spurious);

endmodule

// File: tb/tb_zeroriscy_d_arb.sv
// tb_zeroriscy_d_arb: directed bench for the two-master data-SRAM arbiter.
// Keeps a queue-level model of ownership plus a behavioural SRAM and master scoreboards.
// Literal expectations pin the model at the interesting cycles of each scenario.
`timescale 1ns/1ps
module tb_zeroriscy_d_arb;
  localparam int MAX_OUT = 2;
  localparam int AW      = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [3:0]    m0_be;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [3:0]    m1_be;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic          s_req, s_we, s_gnt, s_rvalid, s_err;
  logic [3:0]    s_be;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_rdata;

  always #5 clk = ~clk;

  zeroriscy_d_arb #(.MAX_OUT(MAX_OUT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
  );

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
  typedef struct { logic [31:0] data; logic err; } exp_t;

  txn_t        mq0[$], mq1[$];     // pending master requests
  rsp_t        sram_q[$];          // SRAM responses in flight
  exp_t        exp0[$], exp1[$];   // per-master expected responses
  logic [31:0] mem [logic [31:0]];
  bit          owner_q[$];         // model: who owns each outstanding transaction
  bit          m_hold, m_held, m_last;
  int          lat;
  bit          gnt_en, inj_rv;
  int          cyc;
  int          checks, errors;

  // Values sampled mid-cycle, used by the scenarios and by the environment update.
  logic        o_sreq, o_g0, o_g1, o_rv0, o_rv1, o_err0, o_err1, o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_rdata;
  int          o_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] read_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic txn_t rd(input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.be = 4'hF; t.addr = a; t.wdata = 32'h0;
    return t;
  endfunction

  function automatic txn_t wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.be = be; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Expected response for a transaction, taken from the memory contents at acceptance.
  function automatic exp_t expect_of(input txn_t t);
    exp_t e;
    e.err  = t.addr[31];
    e.data = t.we ? 32'h0 : read_mem(t.addr);
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, compare 1ns later, update at the rising edge.
  task automatic step();
    bit pop_ok, exp_req, sel, sram_drove;
    exp_t e;
    rsp_t r;
    logic [31:0] cur;

    if (mq0.size() > 0) begin
      m0_req = 1'b1; m0_we = mq0[0].we; m0_be = mq0[0].be; m0_addr = mq0[0].addr; m0_wdata = mq0[0].wdata;
    end else begin
      m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    end
    if (mq1.size() > 0) begin
      m1_req = 1'b1; m1_we = mq1[0].we; m1_be = mq1[0].be; m1_addr = mq1[0].addr; m1_wdata = mq1[0].wdata;
    end else begin
      m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    end
    if (!rst_n) begin
      owner_q.delete(); sram_q.delete(); exp0.delete(); exp1.delete();
      m_hold = 1'b0; m_held = 1'b0; m_last = 1'b1;
    end
    s_gnt      = gnt_en;
    sram_drove = (sram_q.size() > 0) && (sram_q[0].due <= cyc);
    if (inj_rv) begin
      s_rvalid = 1'b1; s_rdata = 32'hBAD0BAD0; s_err = 1'b0;
    end else if (sram_drove) begin
      s_rvalid = 1'b1; s_rdata = sram_q[0].data; s_err = sram_q[0].err;
    end else begin
      s_rvalid = 1'b0; s_rdata = 32'h0; s_err = 1'b0;
    end
    #1;

    // Model: owners leave in issue order; a full queue only admits when a response frees a slot.
    pop_ok  = rst_n && s_rvalid && (owner_q.size() > 0);
    exp_req = rst_n && (m0_req || m1_req) && ((owner_q.size() < MAX_OUT) || pop_ok);
    if (m_hold) sel = m_held;
    else if (m0_req && m1_req) begin
`ifdef ZERORISCY_D_ARB_RR_EN
      sel = !m_last;
`else
      sel = 1'b0;
`endif
    end else sel = m1_req;

    chk("s_req", 32'(s_req), 32'(exp_req));
    chk("m0_gnt", 32'(m0_gnt), 32'(exp_req && s_gnt && !sel));
    chk("m1_gnt", 32'(m1_gnt), 32'(exp_req && s_gnt && sel));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(pop_ok && owner_q[0] == 1'b0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(pop_ok && owner_q[0] == 1'b1));
    chk("m0_err", 32'(m0_err), 32'(pop_ok && owner_q[0] == 1'b0 && s_err));
    chk("m1_err", 32'(m1_err), 32'(pop_ok && owner_q[0] == 1'b1 && s_err));
    if (exp_req) begin
      chk("s_addr", s_addr, sel ? m1_addr : m0_addr);
      chk("s_we", 32'(s_we), 32'(sel ? m1_we : m0_we));
      chk("s_be", 32'(s_be), 32'(sel ? m1_be : m0_be));
      chk("s_wdata", s_wdata, sel ? m1_wdata : m0_wdata);
    end
    chk("count_bound", 32'(dut.r_count <= MAX_OUT), 32'd1);
    if (m0_rvalid) begin
      if (exp0.size() == 0) chk("m0_unexpected_rsp", 32'd1, 32'd0);
      else begin
        chk("m0_rdata", m0_rdata, exp0[0].data);
        chk("m0_rsp_err", 32'(m0_err), 32'(exp0[0].err));
        void'(exp0.pop_front());
      end
    end
    if (m1_rvalid) begin
      if (exp1.size() == 0) chk("m1_unexpected_rsp", 32'd1, 32'd0);
      else begin
        chk("m1_rdata", m1_rdata, exp1[0].data);
        chk("m1_rsp_err", 32'(m1_err), 32'(exp1[0].err));
        void'(exp1.pop_front());
      end
    end

    o_sreq = s_req; o_g0 = m0_gnt; o_g1 = m1_gnt; o_rv0 = m0_rvalid; o_rv1 = m1_rvalid;
    o_err0 = m0_err; o_err1 = m1_err; o_rdata = s_rdata;
    o_we = s_we; o_be = s_be; o_addr = s_addr; o_wdata = s_wdata;
    o_gid = m0_gnt ? 0 : (m1_gnt ? 1 : -1);

    @(posedge clk);
    if (rst_n) begin
      if (pop_ok) void'(owner_q.pop_front());
      if (exp_req && s_gnt) begin
        owner_q.push_back(sel); m_last = sel; m_hold = 1'b0;
      end else if (exp_req) begin
        m_hold = 1'b1; m_held = sel;
      end
    end
    if (sram_drove && !inj_rv) void'(sram_q.pop_front());
    if (rst_n && o_g0 && mq0.size() > 0) begin
      e = expect_of(mq0[0]); exp0.push_back(e); void'(mq0.pop_front());
    end
    if (rst_n && o_g1 && mq1.size() > 0) begin
      e = expect_of(mq1[0]); exp1.push_back(e); void'(mq1.pop_front());
    end
    if (rst_n && o_sreq && s_gnt) begin
      r.due = cyc + lat;
      r.err = o_addr[31];
      if (o_we) begin
        cur = read_mem(o_addr);
        for (int b = 0; b < 4; b++) if (o_be[b]) cur[8*b +: 8] = o_wdata[8*b +: 8];
        mem[o_addr] = cur;
        r.data = 32'h0;
      end else begin
        r.data = read_mem(o_addr);
      end
      sram_q.push_back(r);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mq0.size() + mq1.size() + sram_q.size() + owner_q.size()) != 0 && n < 60) begin
      step();
      n++;
    end
    chk({"drain_idle_", name}, 32'(n < 60), 32'd1);
    chk({"drain_rsp_", name}, 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  // A lone m1 transaction: leaves m1 as last completer and exercises error routing.
  task automatic m1_err_read();
    mq1.push_back(rd(32'h8000_0004));
    step();
    chk("m1err_gnt", 32'(o_g1), 32'd1);
    step();
    chk("m1err_rvalid", 32'(o_rv1), 32'd1);
    chk("m1err_err", 32'(o_err1), 32'd1);
    chk("m1err_m0_rvalid", 32'(o_rv0), 32'd0);
    drain("m1err");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq [6];
    int n0;
    bit got1;
    logic [31:0] d1;

    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; gnt_en = 1'b1; inj_rv = 1'b0; lat = 1;
    m_hold = 1'b0; m_held = 1'b0; m_last = 1'b1;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h40]  = 32'hAAAAAAAA;
    for (int i = 0; i < 6; i++) begin
      mem[32'h200 + 32'(4*i)] = 32'h2000_0000 + 32'(i);
      mem[32'h300 + 32'(4*i)] = 32'h3000_0000 + 32'(i);
    end
    @(negedge clk);

    // Reset: a pending m0 request with s_gnt high must not be granted.
    mq0.push_back(rd(32'h100));
    step();
    chk("rst_m0_gnt", 32'(o_g0), 32'd0);
    chk("rst_s_req", 32'(o_sreq), 32'd0);
    chk("rst_m0_rvalid", 32'(o_rv0), 32'd0);
    step();
    rst_n = 1'b1;

    // Single read: granted in cycle 0, data back in cycle 1.
    step();
    chk("t1_c0_m0_gnt", 32'(o_g0), 32'd1);
    step();
    chk("t1_c1_m0_rvalid", 32'(o_rv0), 32'd1);
    chk("t1_c1_m0_rdata", o_rdata, 32'hDEADBEEF);
    chk("t1_c1_m1_rvalid", 32'(o_rv1), 32'd0);
    drain("t1");

    // Contention for 6 cycles with full throughput.
    m1_err_read();
    for (int i = 0; i < 6; i++) begin
      mq0.push_back(rd(32'h200 + 32'(4*i)));
      mq1.push_back(rd(32'h300 + 32'(4*i)));
    end
    for (int i = 0; i < 6; i++) begin
      step();
      gseq[i] = o_gid;
    end
    for (int i = 0; i < 6; i++) begin
`ifdef ZERORISCY_D_ARB_RR_EN
      chk($sformatf("t2_grant_%0d", i), 32'(gseq[i]), 32'(i % 2));
`else
      chk($sformatf("t2_grant_%0d", i), 32'(gseq[i]), 32'd0);
`endif
    end
    drain("t2");

    // Owner FIFO full with 3-cycle SRAM: third issue waits for the first response.
    m1_err_read();
    lat = 3;
    mq0.push_back(rd(32'h200));
    mq0.push_back(rd(32'h204));
    mq1.push_back(rd(32'h300));
    step();
    chk("t3_c0_m0_gnt", 32'(o_g0), 32'd1);
    step();
    chk("t3_c1_s_req", 32'(o_sreq), 32'd1);
    step();
    chk("t3_c2_stall", 32'(o_sreq), 32'd0);
    step();
    chk("t3_c3_s_req", 32'(o_sreq), 32'd1);
    chk("t3_c3_m0_rvalid", 32'(o_rv0), 32'd1);
    chk("t3_c3_rdata", o_rdata, 32'h2000_0000);
    drain("t3");
    lat = 1;

    // SRAM stall: m1 held on the bus while m0 joins, then m1 first, m0 next.
    gnt_en = 1'b0;
    mq1.push_back(rd(32'h304));
    step();
    chk("t4_c0_s_req", 32'(o_sreq), 32'd1);
    chk("t4_c0_m1_gnt", 32'(o_g1), 32'd0);
    mq0.push_back(rd(32'h208));
    step();
    chk("t4_c1_s_addr", o_addr, 32'h304);
    step();
    chk("t4_c2_s_addr", o_addr, 32'h304);
    gnt_en = 1'b1;
    step();
    chk("t4_c3_m1_gnt", 32'(o_g1), 32'd1);
    step();
    chk("t4_c4_m0_gnt", 32'(o_g0), 32'd1);
    drain("t4");

    // Partial write by m0 then read-back by m1.
    m1_err_read();
    mq0.push_back(wr(32'h40, 4'b0011, 32'h12345678));
    mq1.push_back(rd(32'h40));
    n0 = 0; got1 = 1'b0; d1 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_rv0) n0++;
      if (o_rv1) begin got1 = 1'b1; d1 = o_rdata; end
    end
    chk("t5_m0_rvalid_pulses", 32'(n0), 32'd1);
    chk("t5_m1_got_rsp", 32'(got1), 32'd1);
    chk("t5_m1_rdata_lo", {16'h0, d1[15:0]}, 32'h0000_5678);
    drain("t5");

    // Reset with two outstanding, then a stray response.
    lat = 3;
    mq0.push_back(rd(32'h200));
    mq0.push_back(rd(32'h204));
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lat = 1;
    inj_rv = 1'b1;
    step();
    chk("t6_m0_rvalid", 32'(o_rv0), 32'd0);
    chk("t6_m1_rvalid", 32'(o_rv1), 32'd0);
    chk("t6_count", 32'(dut.r_count), 32'd0);
    chk("t6_spurious_flag", 32'(dut.r_spurious), 32'd1);
    inj_rv = 1'b0;
    mq0.push_back(rd(32'h100));
    step();
    step();
    chk("t6_after_rvalid", 32'(o_rv0), 32'd1);
    chk("t6_after_rdata", o_rdata, 32'hDEADBEEF);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
